// File: rtl/elastic_token_fifo.sv
// Two-phase (toggle) handshake token FIFO with a registered output stage,
// optional two-flop input synchronisers and reset-time preloaded tokens.
module elastic_token_fifo #(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 4,
  parameter int                INIT_TOKENS = 0,
  parameter logic [DATA_W-1:0] INIT_DATA   = '0,
  parameter int                SYNC        = 0
) (
  input  logic                         clk,
  input  logic                         preset,
  input  logic                         Rin,
  input  logic [DATA_W-1:0]            din,
  output logic                         Ain,
  output logic                         Rout,
  output logic [DATA_W-1:0]            dout,
  input  logic                         Aout,
  output logic                         lt_en,
  output logic [$clog2(DEPTH+2)-1:0]   occ,
  output logic                         proto_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 2);
  localparam logic [PW-1:0] LAST      = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] INIT_CNT  = CW'(INIT_TOKENS);
  localparam logic [PW-1:0] INIT_TAIL = PW'(INIT_TOKENS % DEPTH);
  localparam logic [OW-1:0] INIT_OCC  = OW'(INIT_TOKENS);

  logic rin_s;
  logic aout_s;

  generate
    if (SYNC == 2) begin : g_sync
      logic [1:0] rin_q;
      logic [1:0] aout_q;
      always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
          rin_q  <= '0;
          aout_q <= '0;
        end else begin
          rin_q  <= {rin_q[0], Rin};
          aout_q <= {aout_q[0], Aout};
        end
      end
      assign rin_s  = rin_q[1];
      assign aout_s = aout_q[1];
    end else begin : g_direct
      assign rin_s  = Rin;
      assign aout_s = Aout;
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nx;
  logic [OW-1:0]     occ_nx;
  logic              rin_d;
  logic              aout_d;
  logic              pending;
  logic              busy;
  logic              accept;
  logic              launch;
  logic              rout_nx;
  logic              err_nx;

  always_comb begin
    pending  = rin_s != Ain;
    busy     = Rout != aout_s;
    launch   = !busy && (count != '0);
    // accept looks at the pre-edge count, so a full FIFO never accepts
    // on the same edge that frees a slot
    accept   = pending && (count != FULL);
    count_nx = count;
    if (accept && !launch)
      count_nx = count + 1'b1;
    else if (launch && !accept)
      count_nx = count - 1'b1;
    rout_nx  = Rout ^ launch;
    occ_nx   = OW'(count_nx) + {{(OW-1){1'b0}}, rout_nx != aout_s};
    err_nx   = ((rin_s != rin_d) && (rin_d != Ain))
            || ((aout_s != aout_d) && (aout_d == Rout));
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      Ain       <= 1'b0;
      Rout      <= 1'b0;
      dout      <= '0;
      lt_en     <= 1'b0;
      proto_err <= 1'b0;
      head      <= '0;
      tail      <= INIT_TAIL;
      count     <= INIT_CNT;
      occ       <= INIT_OCC;
      rin_d     <= 1'b0;
      aout_d    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < INIT_TOKENS) ? INIT_DATA : '0;
    end else begin
      if (accept) begin
        mem[tail] <= din;
        tail      <= (tail == LAST) ? '0 : tail + 1'b1;
        Ain       <= ~Ain;
      end
      if (launch) begin
        dout <= mem[head];
        head <= (head == LAST) ? '0 : head + 1'b1;
      end
      Rout      <= rout_nx;
      lt_en     <= launch;
      count     <= count_nx;
      occ       <= occ_nx;
      rin_d     <= rin_s;
      aout_d    <= aout_s;
      proto_err <= proto_err | err_nx;
    end
  end
endmodule

// File: tb/tb_elastic_token_fifo.sv
// Bench for elastic_token_fifo: three instances (plain, preloaded DEPTH=3,
// synchronised) against a queue-based token model plus directed checks.
module tb_elastic_token_fifo;
  function automatic int dep_of(input int g);
    return (g == 1) ? 3 : 4;
  endfunction
  function automatic int init_of(input int g);
    return (g == 1) ? 2 : 0;
  endfunction
  function automatic int sync_of(input int g);
    return (g == 2) ? 2 : 0;
  endfunction
  function automatic logic [7:0] idat_of(input int g);
    return (g == 1) ? 8'h3C : 8'h00;
  endfunction

  localparam logic [3:0][7:0] DRAIN = {8'h66, 8'h04, 8'h03, 8'h02};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            preset;
  logic [2:0]      rin, aout, ain, rout, lt, perr;
  logic [2:0][7:0] din, dout;
  logic [2:0][2:0] occ;

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    elastic_token_fifo #(
      .DATA_W(8),
      .DEPTH(dep_of(g)),
      .INIT_TOKENS(init_of(g)),
      .INIT_DATA(idat_of(g)),
      .SYNC(sync_of(g))
    ) u_dut (
      .clk(clk),
      .preset(preset),
      .Rin(rin[g]),
      .din(din[g]),
      .Ain(ain[g]),
      .Rout(rout[g]),
      .dout(dout[g]),
      .Aout(aout[g]),
      .lt_en(lt[g]),
      .occ(occ[g]),
      .proto_err(perr[g])
    );
  end

  logic [7:0]      mq [3][$];
  logic [2:0]      m_ain, m_rout, m_lt, m_err, m_rd, m_ad;
  logic [2:0][7:0] m_dout;
  logic [2:0][1:0] rh, ah;
  int              m_occ [3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    logic rs, as_, pnd, bsy, acc, lau;
    forever begin
      @(posedge clk);
      for (int g = 0; g < 3; g++) begin
        if (preset) begin
          mq[g].delete();
          for (int k = 0; k < init_of(g); k++)
            mq[g].push_back(idat_of(g));
          m_ain[g] = 0; m_rout[g] = 0; m_lt[g] = 0; m_err[g] = 0;
          m_rd[g] = 0; m_ad[g] = 0; m_dout[g] = 8'h00;
          rh[g] = 2'b00; ah[g] = 2'b00;
          m_occ[g] = init_of(g);
        end else begin
          rs  = (sync_of(g) == 2) ? rh[g][1] : rin[g];
          as_ = (sync_of(g) == 2) ? ah[g][1] : aout[g];
          rh[g] = {rh[g][0], rin[g]};
          ah[g] = {ah[g][0], aout[g]};
          pnd = rs != m_ain[g];
          bsy = m_rout[g] != as_;
          lau = !bsy && (mq[g].size() > 0);
          acc = pnd && (mq[g].size() < dep_of(g));
          if ((rs != m_rd[g] && m_rd[g] != m_ain[g]) ||
              (as_ != m_ad[g] && m_ad[g] == m_rout[g]))
            m_err[g] = 1;
          m_lt[g] = lau;
          if (lau) begin
            m_dout[g] = mq[g].pop_front();
            m_rout[g] = ~m_rout[g];
          end
          if (acc) begin
            mq[g].push_back(din[g]);
            m_ain[g] = ~m_ain[g];
          end
          m_occ[g] = mq[g].size() + int'(m_rout[g] != as_);
          m_rd[g] = rs;
          m_ad[g] = as_;
        end
      end
      #1;
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("i%0d_ain", g), ain[g], m_ain[g]);
        chk($sformatf("i%0d_rout", g), rout[g], m_rout[g]);
        chk($sformatf("i%0d_dout", g), dout[g], m_dout[g]);
        chk($sformatf("i%0d_lt_en", g), lt[g], m_lt[g]);
        chk($sformatf("i%0d_occ", g), occ[g], m_occ[g]);
        chk($sformatf("i%0d_err", g), perr[g], m_err[g]);
      end
    end
  endtask

  task automatic rand_cycles(input int n, input int pin, input int pout);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (rin[g] == ain[g] && $urandom_range(0, 99) < pin) begin
          din[g] = 8'($urandom);
          rin[g] = ~rin[g];
        end
        if (rout[g] != aout[g] && $urandom_range(0, 99) < pout)
          aout[g] = ~aout[g];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic r_exp, o_exp;

  initial begin
    preset = 1'b1;
    rin = '0; aout = '0; din = '0;
    fork
      model_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ain0", ain[0], 0);
    chk("rst_occ0", occ[0], 0);
    chk("rst_occ1", occ[1], 2);
    chk("rst_rout1", rout[1], 0);
    chk("rst_err0", perr[0], 0);

    // preloaded instance launches on the first edge after release
    @(negedge clk); preset = 1'b0;
    step();
    chk("pre_rout1", rout[1], 1);
    chk("pre_dout1", dout[1], 8'h3C);
    chk("pre_lt1", lt[1], 1);
    chk("pre_occ1", occ[1], 2);

    @(negedge clk); aout[1] = 1'b1; din[0] = 8'hA5; rin[0] = 1'b1;
    step();
    chk("a5_ain0", ain[0], 1);
    chk("a5_rout0", rout[0], 0);
    chk("a5_occ0", occ[0], 1);
    chk("pre2_rout1", rout[1], 0);
    chk("pre2_lt1", lt[1], 1);
    chk("pre2_occ1", occ[1], 1);
    step();
    chk("a5_rout0b", rout[0], 1);
    chk("a5_dout0", dout[0], 8'hA5);
    chk("a5_lt0", lt[0], 1);
    chk("a5_occ0b", occ[0], 1);

    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) aout[1] = 1'b0;
      din[0] = 8'(i);
      rin[0] = ~rin[0];
      step();
    end
    chk("full_occ0", occ[0], 5);
    chk("full_ain0", ain[0], 1);
    chk("idle_occ1", occ[1], 0);

    @(negedge clk); din[0] = 8'h66; rin[0] = 1'b0;
    step();
    step();
    chk("stall_ain0", ain[0], 1);
    chk("stall_occ0", occ[0], 5);
    chk("stall_lt0", lt[0], 0);

    @(negedge clk); aout[0] = 1'b1;
    step();
    chk("ack_dout0", dout[0], 8'h01);
    chk("ack_ain0", ain[0], 1);
    chk("ack_occ0", occ[0], 4);
    step();
    chk("refill_ain0", ain[0], 0);
    chk("refill_occ0", occ[0], 5);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); aout[0] = rout[0];
      step();
      chk($sformatf("drain%0d", i), dout[0], DRAIN[i]);
    end
    @(negedge clk); aout[0] = rout[0];
    step();
    chk("empty_occ0", occ[0], 0);

    rand_cycles(1500, 50, 50);
    rand_cycles(1000, 90, 20);
    rand_cycles(1000, 20, 90);
    rand_cycles(200, 0, 100);

    // synchronised instance: two extra cycles on the request path
    @(negedge clk);
    din[2] = 8'h5A; rin[2] = ~rin[2];
    r_exp = rin[2]; o_exp = ~aout[2];
    step();
    chk("s2_ain_n", ain[2], !r_exp);
    step();
    chk("s2_ain_n1", ain[2], !r_exp);
    step();
    chk("s2_ain_n2", ain[2], r_exp);
    chk("s2_rout_n2", rout[2], !o_exp);
    step();
    chk("s2_rout_n3", rout[2], o_exp);
    chk("s2_dout_n3", dout[2], 8'h5A);
    chk("s2_lt_n3", lt[2], 1);
    rand_cycles(20, 0, 100);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk); din[0] = 8'(8'h10 + i); rin[0] = ~rin[0];
      step();
    end
    chk("err_full_occ0", occ[0], 5);
    chk("err_pre0", perr[0], 0);
    @(negedge clk); rin[0] = ~rin[0];
    step();
    chk("err_set0", perr[0], 1);
    repeat (3) step();
    chk("err_hold0", perr[0], 1);
    chk("err_other1", perr[1], 0);

    @(negedge clk); preset = 1'b1; rin = '0; aout = '0;
    #1;
    chk("mid_occ0", occ[0], 0);
    chk("mid_occ1", occ[1], 2);
    chk("mid_err0", perr[0], 0);
    chk("mid_rout0", rout[0], 0);
    chk("mid_ain0", ain[0], 0);
    chk("mid_dout0", dout[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk); preset = 1'b0;
    rand_cycles(600, 60, 60);
    rand_cycles(200, 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elastic_token_fifo.md
ELASTIC_TOKEN_FIFO -- requirements
Module: elastic_token_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of the bundled data word.
REQ-002 Parameter DEPTH, default 4, storage slots (2..16), excluding the output register.
REQ-003 Parameter INIT_TOKENS, default 0, tokens preloaded at reset (0..DEPTH).
REQ-004 Parameter INIT_DATA, default 0, DATA_W-bit value of every preloaded token.
REQ-005 Parameter SYNC, default 0, input synchroniser stages on Rin and Aout (0 or 2 only).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 preset  input  1  asynchronous, active-high reset.
REQ-008 Rin  input  1  two-phase request; a toggle offers a new token.
REQ-009 din  input  DATA_W  bundled data; stable while Rin_s != Ain.
REQ-010 Ain  output  1  two-phase acknowledge to upstream.
REQ-011 Rout  output  1  two-phase request to downstream.
REQ-012 dout  output  DATA_W  data of the token being offered; stable while Rout != Aout_s.
REQ-013 Aout  input  1  two-phase acknowledge from downstream.
REQ-014 lt_en  output  1  one-cycle pulse on the edge that launches a token on Rout.
REQ-015 occ  output  $clog2(DEPTH+2)  tokens held: stored count plus 1 if output outstanding.
REQ-016 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-017 Rin_s and Aout_s SHALL equal Rin/Aout directly when SYNC=0, and after two clk flops when SYNC=2.
REQ-018 Input pending SHALL be Rin_s != Ain; output busy SHALL be Rout != Aout_s.
REQ-019 On an edge with input pending and stored count < DEPTH, the block SHALL write din at the tail, advance the tail pointer (mod DEPTH), and toggle Ain.
REQ-020 With stored count == DEPTH, input SHALL stall with Ain held; no write occurs.
REQ-021 On an edge with output not busy and stored count > 0, the block SHALL load dout from head, advance head (mod DEPTH), toggle Rout, and assert lt_en for that cycle.
REQ-022 Empty (stored count 0) with output idle SHALL leave Rout, dout unchanged and lt_en low.
REQ-023 No bypass: a token accepted on edge n SHALL launch no earlier than edge n+1.
REQ-024 Simultaneous accept and launch on one edge SHALL leave stored count unchanged; when full, a same-edge launch SHALL NOT permit an accept on that edge.
REQ-025 A downstream ack (Aout_s becoming equal to Rout) SHALL decrement occ on the following edge.
REQ-026 Latency (SYNC=0, empty, output idle): Rin toggle before edge n -> Ain toggle at edge n -> Rout toggle at edge n+1.
REQ-027 With SYNC=2, each path SHALL add exactly 2 cycles of latency.
REQ-028 Pointers SHALL wrap modulo DEPTH for non-power-of-two DEPTH.
REQ-029 proto_err SHALL set if Rin_s changes while input pending and not accepted that edge (request withdrawn), or Aout_s changes while output not busy; cleared only by preset.

Reset
REQ-030 While preset is high: Ain=0, Rout=0, dout=0, lt_en=0, proto_err=0, synchroniser flops=0, head=0.
REQ-031 While preset is high: stored count=INIT_TOKENS, tail=INIT_TOKENS mod DEPTH, slots 0..INIT_TOKENS-1 = INIT_DATA.
REQ-032 Preset asserted mid-transfer SHALL discard all in-flight tokens and restore REQ-030/031 values immediately.
REQ-033 With INIT_TOKENS>0, the first edge after preset deassert SHALL launch: Rout=1, dout=INIT_DATA, lt_en=1.

Verification
REQ-034 DEPTH=4, SYNC=0: toggle Rin with din=0xA5 -> Ain toggles next edge, Rout toggles edge after, dout=0xA5, occ=1.
REQ-035 Aout held: 5 Rin toggles -> 1 launched + 4 stored, occ=5, 6th toggle stalls with Ain unchanged.
REQ-036 Full, ack downstream and toggle Rin together -> launch and accept order per REQ-024, occ returns to 5, FIFO order preserved across wrap.
REQ-037 INIT_TOKENS=2, INIT_DATA=0x3C: release preset -> Rout=1, dout=0x3C, occ=2; ack -> second 0x3C launches.
REQ-038 SYNC=2: single token -> Ain at edge n+2, Rout at edge n+3.
REQ-039 Toggle Rin then retract it while full -> proto_err=1, stays 1 until preset; preset mid-stream -> occ=INIT_TOKENS.
